// File: rtl/bcd_pkg.sv
// Shared types and helpers for the digit-serial BCD adder/subtractor.
//   bcd_digit_t    : one packed-BCD digit
//   BCD_MAX        : largest legal digit value
//   addsub_state_t : sequencer states
//   nines_comp()   : 9 - d, the per-digit nines complement
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StAdd,
        StRecomp,
        StFin
    } addsub_state_t;

    // Only meaningful for legal digits; illegal digits never reach the datapath result.
    function automatic bcd_digit_t nines_comp(input bcd_digit_t d);
        return BCD_MAX - d;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Single-digit decimal adder: x + y + carry-in, decimal-adjusted.
// Ports:
//   x_i, y_i : BCD digits (0..9)
//   c_i      : carry in
//   s_o      : decimal-adjusted sum digit (0..9)
//   c_o      : decimal carry out
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t x_i,
    input  bcd_digit_t y_i,
    input  logic       c_i,
    output bcd_digit_t s_o,
    output logic       c_o
);

    // Max 9 + 9 + 1 = 19, so five bits always suffice.
    logic [4:0] sum;

    always_comb begin
        sum = {1'b0, x_i} + {1'b0, y_i} + {4'b0000, c_i};
        if (sum > 5'd9) begin
            s_o = 4'(sum - 5'd10);
            c_o = 1'b1;
        end else begin
            s_o = sum[3:0];
            c_o = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial N-digit packed-BCD adder/subtractor, one digit per clock, LSD first.
// Subtraction uses tens complement; a negative difference is re-complemented in a second
// serial pass so the result is always sign + magnitude.
// Ports:
//   clk, nrst : clock (rising edge), asynchronous active-low reset
//   start     : request, accepted only from idle when no done pulse is showing
//   op        : 0 = a + b, 1 = a - b (sampled with start)
//   a, b      : packed-BCD operands, digit 0 in bits [3:0] (sampled with start)
//   busy      : operation in progress
//   done      : one-cycle completion pulse; result/flags are valid from this cycle on
//   result    : packed-BCD sum or difference magnitude, held until the next completion
//   carry     : add only, decimal carry out of the MSD
//   neg       : subtract only, set when a < b
//   err       : an operand digit was > 9
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int unsigned NDIGITS = 4
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic                   op,
    input  logic [4*NDIGITS-1:0]   a,
    input  logic [4*NDIGITS-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [4*NDIGITS-1:0]   result,
    output logic                   carry,
    output logic                   neg,
    output logic                   err
);

    localparam int unsigned W    = 4 * NDIGITS;
    localparam int unsigned IdxW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIGITS - 1);

    addsub_state_t   state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    r_q, r_d;      // working result, shifted in from the MSD end
    logic            op_q, op_d;
    logic            c_q, c_d;      // running decimal carry
    logic            negw_q, negw_d;
    logic            errw_q, errw_d;
    logic            done_q, done_d;
    logic [W-1:0]    res_q, res_d;
    logic            carry_q, carry_d;
    logic            neg_q, neg_d;
    logic            err_q, err_d;

    bcd_digit_t add_x, add_y, add_s;
    logic       add_ci, add_co;
    logic       bad_digit;
    logic       accept;

    // Both passes share one digit adder; RECOMP feeds 9 - r[i] with a zero addend.
    always_comb begin
        add_ci = c_q;
        if (state_q == StRecomp) begin
            add_x = nines_comp(r_q[3:0]);
            add_y = '0;
        end else begin
            add_x = a_q[3:0];
            add_y = op_q ? nines_comp(b_q[3:0]) : b_q[3:0];
        end
    end

    bcd_digit_add u_digit_add (
        .x_i (add_x),
        .y_i (add_y),
        .c_i (add_ci),
        .s_o (add_s),
        .c_o (add_co)
    );

    // Operands are still unshifted during the first ADD cycle, so all digits are checked there.
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < int'(NDIGITS); k++) begin
            if (a_q[4*k +: 4] > BCD_MAX || b_q[4*k +: 4] > BCD_MAX) begin
                bad_digit = 1'b1;
            end
        end
    end

    // A start coinciding with the done pulse is not taken.
    assign accept = start && (state_q == StIdle) && !done_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        op_d    = op_q;
        c_d     = c_q;
        negw_d  = negw_q;
        errw_d  = errw_q;
        done_d  = 1'b0;
        res_d   = res_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    c_d     = op;
                    idx_d   = '0;
                    negw_d  = 1'b0;
                    errw_d  = 1'b0;
                    state_d = StAdd;
                end
            end

            StAdd: begin
                if (idx_q == '0 && bad_digit) begin
                    errw_d  = 1'b1;
                    r_d     = '0;
                    c_d     = 1'b0;
                    state_d = StFin;
                end else begin
                    r_d   = (r_q >> 4) | (W'(add_s) << (W - 4));
                    a_d   = a_q >> 4;
                    b_d   = b_q >> 4;
                    c_d   = add_co;
                    idx_d = idx_q + IdxW'(1);
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (!op_q) begin
                            state_d = StFin;
                        end else if (add_co) begin
                            // Non-negative difference: the tens-complement carry is not reported.
                            c_d     = 1'b0;
                            state_d = StFin;
                        end else begin
                            c_d     = 1'b1;
                            negw_d  = 1'b1;
                            state_d = StRecomp;
                        end
                    end
                end
            end

            StRecomp: begin
                r_d   = (r_q >> 4) | (W'(add_s) << (W - 4));
                c_d   = add_co;
                idx_d = idx_q + IdxW'(1);
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    c_d     = 1'b0;
                    state_d = StFin;
                end
            end

            StFin: begin
                res_d   = r_q;
                carry_d = c_q;
                neg_d   = negw_q;
                err_d   = errw_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            op_q    <= 1'b0;
            c_q     <= 1'b0;
            negw_q  <= 1'b0;
            errw_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            op_q    <= op_d;
            c_q     <= c_d;
            negw_q  <= negw_d;
            errw_q  <= errw_d;
            done_q  <= done_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign result = res_q;
    assign carry  = carry_q;
    assign neg    = neg_q;
    assign err    = err_q;

endmodule
